// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit holding the HI/LO pair.
//
// Ports:
//   clk   - single clock; every register updates on its rising edge
//   reset - synchronous, active-high; clears state, counter, operands, HI/LO
//   start - the E-stage instruction is an MD op this cycle
//   op    - 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; others no-op
//   A, B  - rs / rt operands (already forwarded)
//   busy  - a mult/div is in progress (derived from registered state only)
//   HI/LO - registered result registers
//
// States:
//   state  | meaning
//   S_IDLE | waiting; accepts mult/div starts and mthi/mtlo writes
//   S_MUL  | multiply in flight; the counter is counting down
//   S_DIV  | divide in flight; the counter is counting down
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    a_q, a_d, b_q, b_d;
  logic           sgn_q, sgn_d;
  logic [31:0]    hi_q, hi_d, lo_q, lo_d;
  logic           done;

  // The last busy cycle is the one in which the counter sits at 1.
  assign done = (state_q != S_IDLE) && (cnt_q <= CW'(1));

  // Products from the latched operands.
  logic [63:0]        prod_u;
  logic signed [63:0] prod_s;
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};
  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});

  // Signed division goes through magnitudes so that 0x80000000 / -1
  // wraps naturally to 0x80000000 with remainder 0.
  logic        neg_a, neg_b;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;
  assign neg_a = sgn_q & a_q[31];
  assign neg_b = sgn_q & b_q[31];
  assign a_mag = neg_a ? (~a_q + 32'd1) : a_q;
  assign b_mag = neg_b ? (~b_q + 32'd1) : b_q;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign quo   = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
  assign rem   = neg_a ? (~r_mag + 32'd1) : r_mag;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    case (state_q)
      S_IDLE: begin
        if (start && (op[2] == 1'b0)) begin
          a_d   = A;
          b_d   = B;
          sgn_d = ~op[0];
          if (op[1] == 1'b0) begin
            state_d = S_MUL;
            cnt_d   = CW'(MULT_CYCLES);
          end else begin
            state_d = S_DIV;
            cnt_d   = CW'(DIV_CYCLES);
          end
        end
      end
      S_MUL, S_DIV: begin
        if (done) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start && (op == 3'b100)) hi_d = A;
        if (start && (op == 3'b101)) lo_d = A;
      end
      S_MUL: begin
        if (done) begin
          if (sgn_q) {hi_d, lo_d} = prod_s;
          else       {hi_d, lo_d} = prod_u;
        end
      end
      S_DIV: begin
        // Divide by zero runs the full latency but leaves HI/LO untouched.
        if (done && (b_q != 32'd0)) begin
          hi_d = rem;
          lo_d = quo;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: E-stage instruction is an MD op this cycle.
REQ-006 SHALL have port op, input, 3: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; other codes are no-op.
REQ-007 SHALL have port A, input, 32: rs operand, already forwarded.
REQ-008 SHALL have port B, input, 32: rt operand, already forwarded.
REQ-009 SHALL have port busy, output, 1: a mult/div is in progress; the hazard unit stalls D-stage MD instructions on busy||start.
REQ-010 SHALL have port HI, output, 32: HI register value, registered.
REQ-011 SHALL have port LO, output, 32: LO register value, registered.

Function
REQ-012 SHALL implement a state machine with states IDLE, MUL, DIV plus a down-counter wide enough for max(MULT_CYCLES, DIV_CYCLES).
REQ-013 In IDLE, with start=1 and op in {000..011} sampled at edge k, SHALL latch A, B and op, enter MUL or DIV, and load the counter with the matching cycle count.
REQ-014 busy SHALL be 1 from edge k through edge k+N, giving exactly N busy cycles (N = MULT_CYCLES or DIV_CYCLES).
REQ-015 busy SHALL be a registered output and SHALL NOT depend combinationally on start.
REQ-016 At edge k+N the block SHALL write HI/LO, return to IDLE and drop busy; the new HI/LO SHALL be visible in the cycle after that edge.
REQ-017 mult SHALL form the signed 64-bit product A*B; multu SHALL form the unsigned 64-bit product; HI = bits[63:32], LO = bits[31:0].
REQ-018 div SHALL write LO = signed quotient truncated toward zero and HI = remainder carrying the sign of the dividend; divu SHALL write the unsigned quotient to LO and the unsigned remainder to HI.
REQ-019 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-020 Division by zero (B=0) SHALL run the full DIV_CYCLES latency and leave HI and LO unchanged.
REQ-021 mthi/mtlo with start=1 in IDLE SHALL write A to HI/LO at that edge, with no busy cycle; the other register SHALL be unchanged.
REQ-022 start=1 while busy=1 SHALL be ignored: no relatch, no counter reload, no HI/LO write.
REQ-023 start=1 with an undefined op code SHALL change no state.
REQ-024 Changes to A, B or op during busy SHALL NOT affect the result.
REQ-025 HI and LO SHALL hold their values in every cycle without a write.

Reset
REQ-026 With reset=1 at an edge, SHALL set state=IDLE, counter=0, busy=0, HI=0, LO=0, and clear the latched operands.
REQ-027 Reset SHALL take priority over start and over a result write at the same edge.
REQ-028 Reset during MUL/DIV SHALL abort the operation, discard the result and leave HI=LO=0.

Verification
REQ-029 multu A=0xFFFFFFFF, B=2 -> busy high exactly 5 cycles, then HI=0x00000001, LO=0xFFFFFFFE.
REQ-030 mult A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB after 5 busy cycles.
REQ-031 div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); next, div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-032 divu A=100, B=0 after mthi 0x1234 and mtlo 0x5678 -> busy 10 cycles, then HI=0x1234, LO=0x5678 unchanged; mthi/mtlo alone -> busy never asserted.
REQ-033 start multu 3*4, then a second start div at busy cycle 2 with A/B changed -> second start ignored, busy falls after 5 cycles, HI=0, LO=12.
REQ-034 reset pulsed at DIV busy cycle 4 -> next cycle busy=0, HI=LO=0, no later HI/LO write.
